piso_serializer: RTL and testbench

Parallel-in, serial-out shift register with a valid/ready load handshake. It accepts a WIDTH-bit word from a parallel register stage and emits it one bit per clock on a serial line, with an optional even-parity bit at the end. It is the serializing end of the register family and feeds a downstream SIPO deserializer or an off-block serial link. Back-to-back words are sent with no idle gap.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_bit_counter.sv | 26 ++
 rtl/piso_serializer.sv | 83 ++++++++
 tb/tb_piso_serializer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer and its bit counter.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } piso_state_t;

  // Counter must be able to hold FRAME_LEN itself, hence the +1.
  function automatic int cnt_w(input int width, input int parity);
    return $clog2(width + parity + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit-index counter: clears on request, counts up while enabled and
// saturates at MAX so it can never wrap mid-frame.
module piso_bit_counter #(
  parameter int MAX = 7,
  parameter int W   = $clog2(MAX + 2)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load and optional trailing
// even-parity bit; back-to-back frames run with no idle gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int FRAME_LEN = WIDTH + PARITY_EN;
  localparam int CW        = cnt_w(WIDTH, PARITY_EN);
  localparam logic [CW-1:0] PAR_IDX  = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  piso_state_t      state;
  logic [WIDTH-1:0] sreg;
  logic             par;
  logic [CW-1:0]    count;
  logic             at_max;
  logic             load;
  logic             cur_bit;
  logic             par_slot;

  assign busy       = (state == SHIFT);
  assign sout_valid = busy;
  assign last       = busy && at_max;
  assign load_ready = !busy || last;
  assign load       = load_valid && load_ready;

  // Clearing on last keeps the counter at 0 whenever the block is idle.
  piso_bit_counter #(
    .MAX(FRAME_LEN - 1),
    .W  (CW)
  ) u_counter (
    .clk   (clk),
    .clr   (!rst || load || last),
    .en    (busy),
    .count (count),
    .at_max(at_max)
  );

  assign cur_bit  = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  assign par_slot = (PARITY_EN != 0) && (count == PAR_IDX);
  assign sout     = busy && (par_slot ? par : cur_bit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      par   <= 1'b0;
    end else if (load) begin
      state <= SHIFT;
      sreg  <= d;
      par   <= (PARITY_EN != 0) ? ^d : 1'b0;
    end else if (last) begin
      state <= IDLE;
    end else if (busy) begin
      if (MSB_FIRST != 0) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
        sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    busy |-> (count <= LAST_IDX));

  a_sout_quiet: assert property (@(posedge clk) disable iff (!rst)
    !sout_valid |-> !sout);

endmodule

// File: tb/tb_piso_serializer.sv
// Drives three serializer configurations from one stimulus stream and checks
// each against a frame-level model (ordered bit list plus bits-remaining count).
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] d = '0;

  logic [2:0] sout_w, valid_w, last_w, ready_w, busy_w;

  int checks   = 0;
  int failures = 0;

  int cw[3] = '{4, 4, 8};
  int cm[3] = '{1, 0, 1};
  int cp[3] = '{0, 1, 0};

  int          rem[3];
  int          idx[3];
  logic [15:0] frm[3];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .d(d[3:0]), .load_valid(load_valid),
    .load_ready(ready_w[0]), .sout(sout_w[0]), .sout_valid(valid_w[0]),
    .last(last_w[0]), .busy(busy_w[0])
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .d(d[3:0]), .load_valid(load_valid),
    .load_ready(ready_w[1]), .sout(sout_w[1]), .sout_valid(valid_w[1]),
    .last(last_w[1]), .busy(busy_w[1])
  );

  piso_serializer u_dut2 (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid),
    .load_ready(ready_w[2]), .sout(sout_w[2]), .sout_valid(valid_w[2]),
    .last(last_w[2]), .busy(busy_w[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame in transmit order: position k holds the k-th bit on the wire.
  function automatic logic [15:0] build(input int c, input logic [7:0] dd);
    logic [15:0] f = '0;
    logic        p = 1'b0;
    for (int k = 0; k < cw[c]; k++) begin
      f[k] = (cm[c] != 0) ? dd[cw[c]-1-k] : dd[k];
      p    = p ^ dd[k];
    end
    if (cp[c] != 0) f[cw[c]] = p;
    return f;
  endfunction

  task automatic applyStimulus(input logic r, input logic lv, input logic [7:0] dv);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      logic ev;
      ev = (rem[c] > 0);
      checkOutput($sformatf("valid%0d", c), 32'(valid_w[c]), 32'(ev));
      checkOutput($sformatf("busy%0d", c),  32'(busy_w[c]),  32'(ev));
      checkOutput($sformatf("last%0d", c),  32'(last_w[c]),  32'(rem[c] == 1));
      checkOutput($sformatf("ready%0d", c), 32'(ready_w[c]), 32'(rem[c] <= 1));
      checkOutput($sformatf("sout%0d", c),  32'(sout_w[c]),  32'(ev ? frm[c][idx[c]] : 1'b0));
    end
    rst        = r;
    load_valid = lv;
    d          = dv;
    for (int c = 0; c < 3; c++) begin
      if (!r) begin
        rem[c] = 0;
        idx[c] = 0;
      end else if (lv && (rem[c] <= 1)) begin
        frm[c] = build(c, dv);
        rem[c] = cw[c] + cp[c];
        idx[c] = 0;
      end else if (rem[c] > 0) begin
        rem[c]--;
        idx[c]++;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      rem[c] = 0;
      idx[c] = 0;
      frm[c] = '0;
    end
    repeat (2) @(posedge clk);

    // Reset held low with a competing load: reset must win.
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);

    applyStimulus(1'b1, 1'b1, 8'h0A);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00);

    applyStimulus(1'b1, 1'b1, 8'h02);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00);

    // Back-to-back: load_valid held high across frame boundaries.
    applyStimulus(1'b1, 1'b1, 8'h02);
    repeat (12) applyStimulus(1'b1, 1'b1, 8'h01);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00);

    // Mid-frame load pulse must be ignored.
    applyStimulus(1'b1, 1'b1, 8'h05);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00);

    // Reset at the second bit aborts the frame; the next load restarts cleanly.
    applyStimulus(1'b1, 1'b1, 8'h0C);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h09);
    repeat (10) applyStimulus(1'b1, 1'b0, 8'h00);

    repeat (400) applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));
    repeat (12) applyStimulus(1'b1, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
